// File: rtl/score_keeper.sv
// score_keeper: single-player scorer with synchronised hit/miss inputs, saturating
// score, round FSM, high-score tracking and registered packed-BCD outputs.
module score_keeper #(
  parameter int DIGITS      = 2,
  parameter int MAX_SCORE   = 99,
  parameter int HIT_PTS     = 1,
  parameter int MISS_PTS    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                GameOver,
  input  logic                restart,
  input  logic                answer,
  input  logic                miss,
  output logic [4*DIGITS-1:0] score_bcd,
  output logic [4*DIGITS-1:0] high_bcd,
  output logic                at_max,
  output logic                new_high,
  output logic                running
);

  localparam int SW = $clog2(MAX_SCORE + 1);
  localparam logic [SW:0] MAX_W  = MAX_SCORE[SW:0];
  localparam logic [SW:0] HIT_W  = HIT_PTS[SW:0];
  localparam logic [SW:0] MISS_W = MISS_PTS[SW:0];

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_OVER = 1'b1
  } state_e;

  function automatic logic [4*DIGITS-1:0] bin2bcd(input logic [SW-1:0] bin);
    logic [4*DIGITS-1:0] bcd;
    bcd = '0;
    for (int i = SW - 1; i >= 0; i--) begin
      for (int d = 0; d < DIGITS; d++) begin
        bcd[4*d +: 4] = (bcd[4*d +: 4] >= 4'd5) ? bcd[4*d +: 4] + 4'd3 : bcd[4*d +: 4];
      end
      bcd = {bcd[4*DIGITS-2:0], bin[i]};
    end
    return bcd;
  endfunction

  logic [SYNC_STAGES-1:0] ans_sync_q;
  logic [SYNC_STAGES-1:0] miss_sync_q;
  logic [SYNC_STAGES-1:0] flush_q;
  logic                   ans_hist_q;
  logic                   miss_hist_q;
  logic                   ans_lvl_s;
  logic                   miss_lvl_s;
  logic                   sync_ok_s;
  logic                   hit_p_s;
  logic                   miss_p_s;

  state_e                 state_q;
  state_e                 state_d;
  logic [SW-1:0]          score_q;
  logic [SW-1:0]          score_d;
  logic [SW-1:0]          high_q;
  logic [SW-1:0]          high_d;
  logic                   new_high_q;
  logic                   new_high_d;
  logic [SW:0]            sum_s;

  logic [4*DIGITS-1:0]    score_bcd_q;
  logic [4*DIGITS-1:0]    high_bcd_q;
  logic                   at_max_q;

  assign ans_lvl_s  = ans_sync_q[SYNC_STAGES-1];
  assign miss_lvl_s = miss_sync_q[SYNC_STAGES-1];
  assign sync_ok_s  = flush_q[SYNC_STAGES-1];
  assign hit_p_s    = sync_ok_s & ans_lvl_s & ~ans_hist_q;
  assign miss_p_s   = sync_ok_s & miss_lvl_s & ~miss_hist_q;
  assign sum_s      = {1'b0, score_q} + HIT_W;

  // Synchronisers and edge history; history holds its reset value of 1 until the
  // pipeline has flushed its reset zeros, so a line held high through reset is not an event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ans_sync_q  <= '0;
      miss_sync_q <= '0;
      flush_q     <= '0;
      ans_hist_q  <= 1'b1;
      miss_hist_q <= 1'b1;
    end else begin
      ans_sync_q  <= {ans_sync_q[SYNC_STAGES-2:0], answer};
      miss_sync_q <= {miss_sync_q[SYNC_STAGES-2:0], miss};
      flush_q     <= {flush_q[SYNC_STAGES-2:0], 1'b1};
      if (sync_ok_s) begin
        ans_hist_q  <= ans_lvl_s;
        miss_hist_q <= miss_lvl_s;
      end
    end
  end

  // Round FSM, scoring and high-score capture.
  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    high_d     = high_q;
    new_high_d = new_high_q;
    case (state_q)
      ST_RUN: begin
        if (GameOver) begin
          state_d = ST_OVER;
          if (score_q > high_q) begin
            high_d     = score_q;
            new_high_d = 1'b1;
          end else begin
            high_d = high_q;
          end
        end else if (restart) begin
          score_d = '0;
        end else if (hit_p_s && !miss_p_s) begin
          score_d = (sum_s > MAX_W) ? MAX_W[SW-1:0] : sum_s[SW-1:0];
        end else if (miss_p_s && !hit_p_s) begin
          score_d = ({1'b0, score_q} >= MISS_W) ? score_q - MISS_W[SW-1:0] : '0;
        end else begin
          score_d = score_q;
        end
      end
      ST_OVER: begin
        if (restart && !GameOver) begin
          state_d    = ST_RUN;
          score_d    = '0;
          new_high_d = 1'b0;
        end else begin
          state_d = ST_OVER;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      score_q    <= '0;
      high_q     <= '0;
      new_high_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      high_q     <= high_d;
      new_high_q <= new_high_d;
    end
  end

  // Display registers trail the binary score/high by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_bcd_q <= '0;
      high_bcd_q  <= '0;
      at_max_q    <= 1'b0;
    end else begin
      score_bcd_q <= bin2bcd(score_q);
      high_bcd_q  <= bin2bcd(high_q);
      at_max_q    <= (score_q == MAX_W[SW-1:0]);
    end
  end

  assign score_bcd = score_bcd_q;
  assign high_bcd  = high_bcd_q;
  assign at_max    = at_max_q;
  assign new_high  = new_high_q;
  assign running   = (state_q == ST_RUN);

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: driver pushes expected outputs from a
// behavioural model, a monitor pops and compares them every clock.
module tb_score_keeper;

  localparam int DIGITS      = 2;
  localparam int MAX_SCORE   = 99;
  localparam int HIT_PTS     = 1;
  localparam int MISS_PTS    = 1;
  localparam int SYNC_STAGES = 2;
  localparam int BW          = 4 * DIGITS;

  logic          clk;
  logic          rst;
  logic          GameOver;
  logic          restart;
  logic          answer;
  logic          miss;
  logic [BW-1:0] score_bcd;
  logic [BW-1:0] high_bcd;
  logic          at_max;
  logic          new_high;
  logic          running;

  score_keeper #(
    .DIGITS     (DIGITS),
    .MAX_SCORE  (MAX_SCORE),
    .HIT_PTS    (HIT_PTS),
    .MISS_PTS   (MISS_PTS),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .GameOver (GameOver),
    .restart  (restart),
    .answer   (answer),
    .miss     (miss),
    .score_bcd(score_bcd),
    .high_bcd (high_bcd),
    .at_max   (at_max),
    .new_high (new_high),
    .running  (running)
  );

  typedef struct {
    int score;
    int high;
    bit at_max;
    bit nh;
    bit run;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model: integer scores plus the sampled history of each line.
  int   m_score;
  int   m_high;
  bit   m_over;
  bit   m_nh;
  bit   qa[$];
  bit   qm[$];
  bit   a_lvl;
  bit   m_lvl;
  bit   go_lvl;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [BW-1:0] to_bcd(input int v);
    logic [BW-1:0] r;
    int div;
    r   = '0;
    div = 1;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'((v / div) % 10);
      div = div * 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_score = 0;
    m_high  = 0;
    m_over  = 1'b0;
    m_nh    = 1'b0;
    qa.delete();
    qm.delete();
    exp_q.delete();
    // Samples before reset release count as high: a held line must rise afresh.
    for (int i = 0; i <= SYNC_STAGES; i++) begin
      qa.push_back(1'b1);
      qm.push_back(1'b1);
    end
  endtask

  task automatic drive_step(input bit a, input bit ms, input bit go, input bit rs);
    exp_t e;
    bit   hit;
    bit   mis;
    answer   = a;
    miss     = ms;
    GameOver = go;
    restart  = rs;
    hit = qa[1] && !qa[0];
    mis = qm[1] && !qm[0];
    qa.push_back(a);
    void'(qa.pop_front());
    qm.push_back(ms);
    void'(qm.pop_front());
    e.score  = m_score;
    e.high   = m_high;
    e.at_max = (m_score == MAX_SCORE);
    if (!m_over) begin
      if (go) begin
        m_over = 1'b1;
        if (m_score > m_high) begin
          m_high = m_score;
          m_nh   = 1'b1;
        end
      end else if (rs) begin
        m_score = 0;
      end else if (hit && !mis) begin
        m_score = (m_score + HIT_PTS > MAX_SCORE) ? MAX_SCORE : m_score + HIT_PTS;
      end else if (mis && !hit) begin
        m_score = (m_score >= MISS_PTS) ? m_score - MISS_PTS : 0;
      end
    end else if (rs && !go) begin
      m_over  = 1'b0;
      m_score = 0;
      m_nh    = 1'b0;
    end
    e.nh  = m_nh;
    e.run = !m_over;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit rs);
    @(negedge clk);
    drive_step(a_lvl, m_lvl, go_lvl, rs);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0);
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin
      a_lvl = 1'b1;
      idle(2);
      a_lvl = 1'b0;
      idle(2);
    end
    idle(6);
  endtask

  task automatic misses(input int n);
    for (int i = 0; i < n; i++) begin
      m_lvl = 1'b1;
      idle(2);
      m_lvl = 1'b0;
      idle(2);
    end
    idle(6);
  endtask

  task automatic do_reset(input bit a_hold);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_score_bcd", 32'(score_bcd), 32'h0);
    chk("rst_high_bcd", 32'(high_bcd), 32'h0);
    chk("rst_at_max", 32'(at_max), 32'h0);
    chk("rst_new_high", 32'(new_high), 32'h0);
    chk("rst_running", 32'(running), 32'h1);
    model_reset();
    a_lvl    = a_hold;
    m_lvl    = 1'b0;
    go_lvl   = 1'b0;
    answer   = a_hold;
    miss     = 1'b0;
    GameOver = 1'b0;
    restart  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    drive_step(a_lvl, m_lvl, go_lvl, 1'b0);
  endtask

  // Monitor: every cycle the DUT presents a fresh output set to compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mon_score_bcd", 32'(score_bcd), 32'(to_bcd(e.score)));
        chk("mon_high_bcd", 32'(high_bcd), 32'(to_bcd(e.high)));
        chk("mon_at_max", 32'(at_max), 32'(e.at_max));
        chk("mon_new_high", 32'(new_high), 32'(e.nh));
        chk("mon_running", 32'(running), 32'(e.run));
      end
    end
  end

  initial begin
    rst      = 1'b1;
    GameOver = 1'b0;
    restart  = 1'b0;
    answer   = 1'b0;
    miss     = 1'b0;
    a_lvl    = 1'b0;
    m_lvl    = 1'b0;
    go_lvl   = 1'b0;
    model_reset();

    // Three separated pulses, then one long hold that counts once.
    do_reset(1'b0);
    idle(4);
    for (int i = 0; i < 3; i++) begin
      a_lvl = 1'b1;
      idle(4);
      a_lvl = 1'b0;
      idle(4);
    end
    idle(4);
    chk("t1_three_hits", 32'(score_bcd), 32'h03);
    a_lvl = 1'b1;
    idle(50);
    a_lvl = 1'b0;
    idle(6);
    chk("t1_held_once", 32'(score_bcd), 32'h04);

    // Saturation at MAX_SCORE and step back down.
    cyc(1'b1);
    idle(4);
    hits(98);
    chk("t2_at_98", 32'(score_bcd), 32'h98);
    hits(3);
    chk("t2_sat_99", 32'(score_bcd), 32'h99);
    chk("t2_at_max_set", 32'(at_max), 32'h1);
    misses(1);
    chk("t2_after_miss", 32'(score_bcd), 32'h98);
    chk("t2_at_max_clr", 32'(at_max), 32'h0);

    // Floor at zero, then simultaneous rises cancel.
    cyc(1'b1);
    idle(4);
    misses(2);
    chk("t3_floor", 32'(score_bcd), 32'h00);
    hits(3);
    a_lvl = 1'b1;
    m_lvl = 1'b1;
    idle(4);
    a_lvl = 1'b0;
    m_lvl = 1'b0;
    idle(6);
    chk("t3_both_cancel", 32'(score_bcd), 32'h03);

    // Round end, frozen score, restart.
    cyc(1'b1);
    idle(2);
    hits(7);
    go_lvl = 1'b1;
    idle(3);
    chk("t4_high_7", 32'(high_bcd), 32'h07);
    chk("t4_new_high", 32'(new_high), 32'h1);
    chk("t4_not_running", 32'(running), 32'h0);
    hits(3);
    chk("t4_frozen", 32'(score_bcd), 32'h07);
    cyc(1'b1);
    idle(2);
    chk("t4_restart_ignored", 32'(running), 32'h0);
    go_lvl = 1'b0;
    idle(1);
    cyc(1'b1);
    idle(2);
    chk("t4_restart_score", 32'(score_bcd), 32'h00);
    chk("t4_restart_high", 32'(high_bcd), 32'h07);
    chk("t4_restart_nh", 32'(new_high), 32'h0);
    chk("t4_restart_run", 32'(running), 32'h1);

    // Equal score is not a new high; a larger one is.
    hits(7);
    go_lvl = 1'b1;
    idle(3);
    chk("t5_equal_nh", 32'(new_high), 32'h0);
    go_lvl = 1'b0;
    cyc(1'b1);
    hits(12);
    go_lvl = 1'b1;
    idle(3);
    chk("t5_high_12", 32'(high_bcd), 32'h12);
    chk("t5_new_high", 32'(new_high), 32'h1);
    go_lvl = 1'b0;
    cyc(1'b1);
    idle(2);

    // Held answer across reset release, then asynchronous reset mid-round.
    do_reset(1'b1);
    idle(10);
    a_lvl = 1'b0;
    idle(6);
    chk("t6_held_no_count", 32'(score_bcd), 32'h00);
    hits(5);
    chk("t6_score_5", 32'(score_bcd), 32'h05);
    do_reset(1'b0);
    idle(4);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) a_lvl = ~a_lvl;
      if ($urandom_range(0, 4) == 0) m_lvl = ~m_lvl;
      if ($urandom_range(0, 59) == 0) go_lvl = ~go_lvl;
      cyc($urandom_range(0, 24) == 0);
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
